// File: rtl/alu_issue_if.sv
// rtl/alu_issue_if.sv - decoded-instruction handshake between decode, issue and ALU stages
interface alu_issue_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;

  logic        out_valid;
  logic        out_ready;
  logic [3:0]  alu_ctl;
  logic [31:0] alu_src1;
  logic [31:0] alu_src2;
  logic [4:0]  out_rd;
  logic        out_wr_en;
  logic [31:0] out_pc;
  logic [2:0]  out_funct3;
  logic        out_illegal;

  modport master (
    output in_valid, instr, pc, rs1_data, rs2_data, out_ready,
    input  in_ready, out_valid, alu_ctl, alu_src1, alu_src2,
           out_rd, out_wr_en, out_pc, out_funct3, out_illegal
  );

  modport slave (
    input  in_valid, instr, pc, rs1_data, rs2_data, out_ready,
    output in_ready, out_valid, alu_ctl, alu_src1, alu_src2,
           out_rd, out_wr_en, out_pc, out_funct3, out_illegal
  );
endinterface

// File: rtl/alu_issue.sv
// rtl/alu_issue.sv - RV32I ALU issue stage: decode, operand forwarding, one-entry skid register
module alu_issue (
  input  logic        clk,
  input  logic        rst_n,
  alu_issue_if.slave  bus,
  input  logic        fwd_ex_en,
  input  logic [4:0]  fwd_ex_rd,
  input  logic [31:0] fwd_ex_data,
  input  logic        fwd_wb_en,
  input  logic [4:0]  fwd_wb_rd,
  input  logic [31:0] fwd_wb_data,
  input  logic        flush
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [3:0] CTL_ADD  = 4'h0;
  localparam logic [3:0] CTL_SUB  = 4'h1;
  localparam logic [3:0] CTL_SLL  = 4'h2;
  localparam logic [3:0] CTL_SLT  = 4'h3;
  localparam logic [3:0] CTL_SLTU = 4'h4;
  localparam logic [3:0] CTL_XOR  = 4'h5;
  localparam logic [3:0] CTL_SRL  = 4'h6;
  localparam logic [3:0] CTL_SRA  = 4'h7;
  localparam logic [3:0] CTL_OR   = 4'h8;
  localparam logic [3:0] CTL_AND  = 4'h9;
  localparam logic [3:0] CTL_BAD  = 4'hF;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd;
  logic [4:0]  rs1_idx;
  logic [4:0]  rs2_idx;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_u;
  logic [31:0] op1;
  logic [31:0] op2;

  logic [3:0]  d_ctl;
  logic [31:0] d_src1;
  logic [31:0] d_src2;
  logic        d_legal;
  logic        d_writes;
  logic        d_wr_en;
  logic        capture;

  assign opcode  = bus.instr[6:0];
  assign rd      = bus.instr[11:7];
  assign funct3  = bus.instr[14:12];
  assign rs1_idx = bus.instr[19:15];
  assign rs2_idx = bus.instr[24:20];
  assign funct7  = bus.instr[31:25];
  assign imm_i   = {{20{bus.instr[31]}}, bus.instr[31:20]};
  assign imm_s   = {{20{bus.instr[31]}}, bus.instr[31:25], bus.instr[11:7]};
  assign imm_u   = {bus.instr[31:12], 12'b0};

  // x0 always reads zero; the younger (EX/MEM) producer wins over MEM/WB
  function automatic logic [31:0] resolve(
    input logic [4:0]  idx,
    input logic [31:0] rf_data,
    input logic        ex_en,
    input logic [4:0]  ex_rd,
    input logic [31:0] ex_data,
    input logic        wb_en,
    input logic [4:0]  wb_rd,
    input logic [31:0] wb_data
  );
    if (idx == 5'd0)
      return 32'd0;
    else if (ex_en && ex_rd == idx)
      return ex_data;
    else if (wb_en && wb_rd == idx)
      return wb_data;
    else
      return rf_data;
  endfunction

  function automatic logic [3:0] arith_ctl(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? CTL_SUB : CTL_ADD;
      3'b001:  return CTL_SLL;
      3'b010:  return CTL_SLT;
      3'b011:  return CTL_SLTU;
      3'b100:  return CTL_XOR;
      3'b101:  return alt ? CTL_SRA : CTL_SRL;
      3'b110:  return CTL_OR;
      default: return CTL_AND;
    endcase
  endfunction

  assign op1 = resolve(rs1_idx, bus.rs1_data, fwd_ex_en, fwd_ex_rd, fwd_ex_data,
                       fwd_wb_en, fwd_wb_rd, fwd_wb_data);
  assign op2 = resolve(rs2_idx, bus.rs2_data, fwd_ex_en, fwd_ex_rd, fwd_ex_data,
                       fwd_wb_en, fwd_wb_rd, fwd_wb_data);

  always_comb begin
    d_ctl    = CTL_ADD;
    d_src1   = op1;
    d_src2   = op2;
    d_legal  = 1'b0;
    d_writes = 1'b0;
    case (opcode)
      OPC_OP: begin
        d_legal  = (funct7 == 7'b0000000) ||
                   (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101));
        d_writes = 1'b1;
        d_ctl    = arith_ctl(funct3, funct7[5]);
      end
      OPC_OPIMM: begin
        d_src2   = imm_i;
        d_writes = 1'b1;
        case (funct3)
          3'b001:  d_legal = (funct7 == 7'b0000000);
          3'b101:  d_legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
          default: d_legal = 1'b1;
        endcase
        // no subi: the immediate's bit 30 only selects sra for funct3 101
        d_ctl = arith_ctl(funct3, funct3 == 3'b101 && funct7[5]);
      end
      OPC_LUI: begin
        d_legal  = 1'b1;
        d_writes = 1'b1;
        d_src1   = 32'd0;
        d_src2   = imm_u;
      end
      OPC_AUIPC: begin
        d_legal  = 1'b1;
        d_writes = 1'b1;
        d_src1   = bus.pc;
        d_src2   = imm_u;
      end
      OPC_LOAD: begin
        d_legal  = 1'b1;
        d_writes = 1'b1;
        d_src2   = imm_i;
      end
      OPC_STORE: begin
        d_legal  = 1'b1;
        d_src2   = imm_s;
      end
      OPC_BRANCH: begin
        d_legal = 1'b1;
        case (funct3)
          3'b000, 3'b001: d_ctl = CTL_SUB;
          3'b100, 3'b101: d_ctl = CTL_SLT;
          3'b110, 3'b111: d_ctl = CTL_SLTU;
          default:        d_legal = 1'b0;
        endcase
      end
      OPC_JAL: begin
        d_legal  = 1'b1;
        d_writes = 1'b1;
        d_src1   = bus.pc;
        d_src2   = 32'd4;
      end
      OPC_JALR: begin
        d_legal  = (funct3 == 3'b000);
        d_writes = 1'b1;
        d_src1   = bus.pc;
        d_src2   = 32'd4;
      end
      default: d_legal = 1'b0;
    endcase
    if (!d_legal) begin
      d_ctl  = CTL_BAD;
      d_src1 = 32'd0;
      d_src2 = 32'd0;
    end
  end

  assign d_wr_en      = d_legal && d_writes && (rd != 5'd0);
  assign bus.in_ready = (!bus.out_valid || bus.out_ready) && !flush;
  assign capture      = bus.in_valid && bus.in_ready;

  // flush is folded into in_ready, so capture can never coincide with it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid   <= 1'b0;
      bus.alu_ctl     <= 4'h0;
      bus.alu_src1    <= 32'd0;
      bus.alu_src2    <= 32'd0;
      bus.out_rd      <= 5'd0;
      bus.out_wr_en   <= 1'b0;
      bus.out_pc      <= 32'd0;
      bus.out_funct3  <= 3'd0;
      bus.out_illegal <= 1'b0;
    end else if (flush) begin
      bus.out_valid <= 1'b0;
    end else if (capture) begin
      bus.out_valid   <= 1'b1;
      bus.alu_ctl     <= d_ctl;
      bus.alu_src1    <= d_src1;
      bus.alu_src2    <= d_src2;
      bus.out_rd      <= rd;
      bus.out_wr_en   <= d_wr_en;
      bus.out_pc      <= bus.pc;
      bus.out_funct3  <= funct3;
      bus.out_illegal <= !d_legal;
    end else if (bus.out_valid && bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have inputs in_valid (1), instr (32), pc (32), rs1_data (32), rs2_data (32): decoded-stage instruction, its PC, and register-file read data.
REQ-004 SHALL have output in_ready (1): stage can accept an instruction this cycle.
REQ-005 SHALL have inputs fwd_ex_en (1), fwd_ex_rd (5), fwd_ex_data (32), fwd_wb_en (1), fwd_wb_rd (5), fwd_wb_data (32): forwarding sources, EX/MEM and MEM/WB.
REQ-006 SHALL have input flush (1): kill held and incoming instruction.
REQ-007 SHALL have input out_ready (1): ALU stage consumes the held instruction.
REQ-008 SHALL have registered outputs out_valid (1), alu_ctl (4), alu_src1 (32), alu_src2 (32), out_rd (5), out_wr_en (1), out_pc (32), out_funct3 (3), out_illegal (1).

Function
REQ-009 SHALL drive in_ready = (!out_valid || out_ready) && !flush, combinationally.
REQ-010 SHALL capture on edge when in_valid && in_ready: out_valid<=1, all payload outputs updated; one-cycle latency.
REQ-011 SHALL clear out_valid when out_ready && out_valid and no capture; payload holds its value otherwise.
REQ-012 SHALL hold all outputs stable while out_valid && !out_ready (stall).
REQ-013 SHALL, on flush, set out_valid<=0 next edge and discard in_valid that cycle; flush wins over capture and stall.
REQ-014 SHALL use alu_ctl encoding: 0 add, 1 sub, 2 sll, 3 slt, 4 sltu, 5 xor, 6 srl, 7 sra, 8 or, 9 and, F invalid.
REQ-015 SHALL decode OP (0110011): funct3 000->add/sub by funct7[5], 001 sll, 010 slt, 011 sltu, 100 xor, 101 srl/sra by funct7[5], 110 or, 111 and; src1=rs1, src2=rs2; funct7 must be 0000000, or 0100000 only for funct3 000/101, else illegal.
REQ-016 SHALL decode OP-IMM (0010011) as OP without sub; src2=sign-extended I-imm; slli requires instr[31:25]=0, srli/srai require instr[31:25]=0000000/0100000, else illegal.
REQ-017 SHALL decode LUI: ctl add, src1=0, src2={instr[31:12],12'b0}; AUIPC: ctl add, src1=pc, src2=U-imm.
REQ-018 SHALL decode LOAD (0000011) ctl add src2=I-imm, STORE (0100011) ctl add src2=S-imm, src1=rs1.
REQ-019 SHALL decode BRANCH (1100011): funct3 000/001->sub, 100/101->slt, 110/111->sltu, src1=rs1, src2=rs2; 010/011 illegal.
REQ-020 SHALL decode JAL and JALR (funct3 000 only): ctl add, src1=pc, src2=32'd4.
REQ-021 SHALL, for any other opcode or illegal field, set alu_ctl=F, out_wr_en=0, out_illegal=1, out_valid=1.
REQ-022 SHALL set out_wr_en=1 iff legal OP, OP-IMM, LUI, AUIPC, LOAD, JAL, JALR and rd!=0.
REQ-023 SHALL resolve each rs operand: index 0 -> 0; else fwd_ex_en && fwd_ex_rd==index -> fwd_ex_data; else fwd_wb_en && fwd_wb_rd==index -> fwd_wb_data; else rs_data; EX priority over WB.
REQ-024 SHALL sample forwarding inputs only in the capture cycle; no re-resolution during stall.
REQ-025 SHALL pass out_funct3=instr[14:12], out_rd=instr[11:7], out_pc=pc.

Reset
REQ-026 SHALL, while rst_n=0, force out_valid=0 and all payload outputs to 0 immediately, regardless of clk.
REQ-027 SHALL, on reset mid-stall, drop the held instruction; first capture allowed on first edge after rst_n rises.

Verification
REQ-028 add x3,x1,x2 with rs1_data=5, rs2_data=7, no fwd -> next cycle out_valid=1, ctl=0, src1=5, src2=7, out_rd=3, wr_en=1.
REQ-029 sub x3,x1,x2, fwd_ex_rd=1 data=0x10, fwd_wb_rd=1 data=0x20, fwd_wb_rd=2 N/A -> src1=0x10 (EX priority), ctl=1.
REQ-030 srai x5,x6,3 (instr[31:25]=0100000) -> ctl=7, src2 low bits=3; instr[31:25]=0000001 -> ctl=F, illegal=1, wr_en=0.
REQ-031 out_ready=0 for 3 cycles with new in_valid -> in_ready=0, outputs unchanged; out_ready=1 -> next instruction captured same edge.
REQ-032 flush asserted with out_valid=1 and in_valid=1 -> next cycle out_valid=0, incoming instruction never appears.
REQ-033 rst_n low mid-stall -> out_valid=0, all outputs 0 without clock edge; addi x0,x0,1 after reset -> wr_en=0.
